sarray_mem_slave: RTL and testbench

SARRAY_MEM_SLAVE -- requirements
Module: sarray_mem_slave

---
 rtl/sarray_mem_slave_pkg.sv | 12 +
 rtl/sarray_rsp_fifo.sv | 59 +++++
 rtl/sarray_mem_slave.sv | 115 +++++++++++
 tb/tb_sarray_mem_slave.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sarray_mem_slave_pkg.sv
// Shared gnpu constants for the systolic-array scratchpad slave: bus widths
// and default read latency and response buffer depth.
package sarray_mem_slave_pkg;
    localparam int ADDR_WIDTH         = 32;
    localparam int SARRAY_LOAD_WIDTH  = 32;
    localparam int SARRAY_STORE_WIDTH = 64;
    localparam int SARRAY_STORE_WORDS = SARRAY_STORE_WIDTH / SARRAY_LOAD_WIDTH;
    localparam int SARRAY_RD_LATENCY  = 2;
    localparam int SARRAY_RSP_DEPTH   = 4;

    typedef logic [SARRAY_LOAD_WIDTH-1:0] sarray_word_t;
endpackage

// File: rtl/sarray_rsp_fifo.sv
// Show-ahead synchronous FIFO holding read responses until the consumer takes them.
module sarray_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] buf_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign do_pop   = pop & ~empty;
    // A pop frees the head slot on the same edge, so a full FIFO may still accept.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = buf_mem[rd_ptr_reg];
    assign count    = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            buf_mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/sarray_mem_slave.sv
// Scratchpad slave: wide multi-word writes, word reads through a fixed-latency
// pipeline into a credit-limited response FIFO.
module sarray_mem_slave
    import sarray_mem_slave_pkg::*;
#(
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_LATENCY = SARRAY_RD_LATENCY,
    parameter int RSP_DEPTH  = SARRAY_RSP_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sarray_ar_valid_i,
    output logic                          sarray_ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]         sarray_ar_addr_i,
    output logic                          sarray_r_valid_o,
    input  logic                          sarray_r_ready_i,
    output logic [SARRAY_LOAD_WIDTH-1:0]  sarray_r_data_o,
    input  logic                          sarray_aw_valid_i,
    output logic                          sarray_aw_ready_o,
    input  logic [ADDR_WIDTH-1:0]         sarray_aw_addr_i,
    input  logic [SARRAY_STORE_WIDTH-1:0] sarray_aw_data_i
);
    localparam int LW         = SARRAY_LOAD_WIDTH;
    localparam int N          = SARRAY_STORE_WORDS;
    localparam int BYTE_SHIFT = $clog2(LW / 8);
    localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W      = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W      = $clog2(RSP_DEPTH + RD_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

    logic                  ar_fire;
    logic                  aw_fire;
    logic [ADDR_WIDTH-1:0] ar_word;
    logic [ADDR_WIDTH-1:0] aw_word;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx [N];
    sarray_word_t          mem [MEM_DEPTH];
    sarray_word_t          pipe_data_reg [RD_LATENCY];
    logic [RD_LATENCY-1:0] pipe_valid_reg;
    logic [OCC_W-1:0]      inflight;
    logic [OCC_W-1:0]      occupancy;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    sarray_word_t          fifo_head;

    // Byte address to word index; anything beyond the array simply aliases.
    assign ar_word = sarray_ar_addr_i >> BYTE_SHIFT;
    assign aw_word = sarray_aw_addr_i >> BYTE_SHIFT;
    assign rd_idx  = IDX_W'(ar_word % DEPTH_A);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_wr_idx
            assign wr_idx[gi] = IDX_W'((aw_word % DEPTH_A + ADDR_WIDTH'(gi)) % DEPTH_A);
        end
    endgenerate

    assign aw_fire = sarray_aw_valid_i & sarray_aw_ready_o;
    assign ar_fire = sarray_ar_valid_i & sarray_ar_ready_o;

    // Non-blocking read of mem gives read-old-data on a same-cycle write.
    always_ff @(posedge clk) begin
        if (aw_fire) begin
            for (int i = 0; i < N; i++) begin
                mem[wr_idx[i]] <= sarray_aw_data_i[i*LW +: LW];
            end
        end
        pipe_data_reg[0] <= mem[rd_idx];
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_data_reg[i] <= pipe_data_reg[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_reg <= '0;
        end else begin
            pipe_valid_reg[0] <= ar_fire;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + OCC_W'(pipe_valid_reg[i]);
        end
    end

    // Every accepted read owns a FIFO slot until popped, so the FIFO cannot overflow.
    assign occupancy         = inflight + OCC_W'(fifo_count);
    assign sarray_ar_ready_o = ~rst & ~fifo_full & (occupancy < OCC_W'(RSP_DEPTH));
    assign sarray_aw_ready_o = ~rst;
    assign sarray_r_valid_o  = ~rst & ~fifo_empty;
    assign sarray_r_data_o   = rst ? '0 : fifo_head;
    assign fifo_pop          = sarray_r_valid_o & sarray_r_ready_i;

    sarray_rsp_fifo #(
        .WIDTH (LW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_valid_reg[RD_LATENCY-1]),
        .push_data (pipe_data_reg[RD_LATENCY-1]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_sarray_mem_slave.sv
// Scoreboard bench for sarray_mem_slave: expected read data queued at acceptance,
// compared when the DUT presents a response.
module tb_sarray_mem_slave;
    import sarray_mem_slave_pkg::*;

    localparam int MEM_DEPTH  = 1024;
    localparam int RD_LATENCY = 2;
    localparam int RSP_DEPTH  = 4;
    localparam int LW         = SARRAY_LOAD_WIDTH;
    localparam int BPW        = SARRAY_LOAD_WIDTH / 8;
    localparam int NW         = SARRAY_STORE_WIDTH / SARRAY_LOAD_WIDTH;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          ar_valid;
    logic                          ar_ready;
    logic [ADDR_WIDTH-1:0]         ar_addr;
    logic                          r_valid;
    logic                          r_ready;
    logic [LW-1:0]                 r_data;
    logic                          aw_valid;
    logic                          aw_ready;
    logic [ADDR_WIDTH-1:0]         aw_addr;
    logic [SARRAY_STORE_WIDTH-1:0] aw_data;

    sarray_mem_slave #(
        .MEM_DEPTH  (MEM_DEPTH),
        .RD_LATENCY (RD_LATENCY),
        .RSP_DEPTH  (RSP_DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .sarray_ar_valid_i (ar_valid),
        .sarray_ar_ready_o (ar_ready),
        .sarray_ar_addr_i  (ar_addr),
        .sarray_r_valid_o  (r_valid),
        .sarray_r_ready_i  (r_ready),
        .sarray_r_data_o   (r_data),
        .sarray_aw_valid_i (aw_valid),
        .sarray_aw_ready_o (aw_ready),
        .sarray_aw_addr_i  (aw_addr),
        .sarray_aw_data_i  (aw_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] data;
        int            acc;
    } exp_t;

    exp_t          exp_q[$];
    logic [LW-1:0] ref_mem [MEM_DEPTH];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            accept_count = 0;
    int            resp_count = 0;
    int            lat;
    bit            head_seen = 1'b0;
    bit            exact_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int widx(input logic [ADDR_WIDTH-1:0] addr);
        longint unsigned a = addr;
        return int'((a / BPW) % MEM_DEPTH);
    endfunction

    function automatic logic [SARRAY_STORE_WIDTH-1:0] rand_store();
        logic [SARRAY_STORE_WIDTH-1:0] v = '0;
        for (int i = 0; i < NW; i++) v[i*LW +: LW] = LW'($urandom());
        return v;
    endfunction

    // Reference model: what the upcoming edge accepts, and the ready it must show.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            checks++;
            if (aw_ready !== 1'b1) begin
                errors++;
                $display("FAIL aw_ready: got %b want 1 (cyc %0d)", aw_ready, cyc);
            end
            checks++;
            if (ar_ready !== (exp_q.size() < RSP_DEPTH)) begin
                errors++;
                $display("FAIL ar_ready: got %b want %b outstanding=%0d (cyc %0d)",
                         ar_ready, (exp_q.size() < RSP_DEPTH), exp_q.size(), cyc);
            end
            if (ar_valid && ar_ready) begin
                exp_q.push_back('{data: ref_mem[widx(ar_addr)], acc: cyc + 1});
                accept_count++;
            end
            if (aw_valid && aw_ready) begin
                for (int i = 0; i < NW; i++)
                    ref_mem[(widx(aw_addr) + i) % MEM_DEPTH] = aw_data[i*LW +: LW];
            end
        end
    end

    // Monitor: one line per response handshake.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            head_seen = 1'b0;
            checks++;
            if ({ar_ready, aw_ready, r_valid} !== 3'b000 || r_data !== '0) begin
                errors++;
                $display("FAIL reset_outputs: ar_ready=%b aw_ready=%b r_valid=%b r_data=%h want all 0",
                         ar_ready, aw_ready, r_valid, r_data);
            end
        end else if (r_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got r_data=%h want no response (cyc %0d)", r_data, cyc);
            end else begin
                if (!head_seen) begin
                    head_seen = 1'b1;
                    lat = cyc - exp_q[0].acc;
                    checks++;
                    if (exact_lat ? (lat != RD_LATENCY) : (lat < RD_LATENCY)) begin
                        errors++;
                        $display("FAIL latency: got %0d want %s%0d", lat, exact_lat ? "" : ">=", RD_LATENCY);
                    end
                end
                if (r_data !== exp_q[0].data) begin
                    errors++;
                    $display("FAIL rsp_data: got %h want %h (cyc %0d)", r_data, exp_q[0].data, cyc);
                end
                if (r_ready) begin
                    $display("rsp %0d: data=%h exp=%h cyc=%0d", resp_count, r_data, exp_q[0].data, cyc);
                    void'(exp_q.pop_front());
                    head_seen = 1'b0;
                    resp_count++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound, input string name, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d outstanding want 0 after %0d cycles", name, exp_q.size(), bound);
        end
        step();
    endtask

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int a0;
        int r0;
        int stalls;
        logic [ADDR_WIDTH-1:0] sv_addr [3];
        rst = 1'b1; ar_valid = 1'b0; ar_addr = '0; r_ready = 1'b1;
        aw_valid = 1'b0; aw_addr = '0; aw_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Fill the whole scratchpad so every later read has a known model value.
        for (int i = 0; i < MEM_DEPTH / NW; i++) begin
            aw_valid = 1'b1; aw_addr = ADDR_WIDTH'(i * NW * BPW); aw_data = rand_store();
            step();
        end
        aw_valid = 1'b0;

        // Write words A0,A1.. at 0, read back with exact latency.
        aw_valid = 1'b1; aw_addr = '0;
        for (int i = 0; i < NW; i++) aw_data[i*LW +: LW] = LW'(32'hA0 + i);
        step();
        aw_valid = 1'b0; exact_lat = 1'b1;
        ar_valid = 1'b1; ar_addr = '0;
        step();
        ar_addr = ADDR_WIDTH'(BPW);
        step();
        ar_valid = 1'b0;
        drain(20, "first_read", n);
        exact_lat = 1'b0;

        // Burst of 16 consecutive words with r_ready high.
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            ar_valid = 1'b1; ar_addr = ADDR_WIDTH'((100 + i) * BPW);
            @(negedge clk);
            if (!ar_ready) stalls++;
            step();
        end
        ar_valid = 1'b0;
        check_eq("burst_ar_stalls", stalls, 0);
        drain(40, "burst", n);
        checks++;
        if (n > RD_LATENCY + 3) begin
            errors++;
            $display("FAIL burst_throughput: got drain of %0d cycles want <= %0d", n, RD_LATENCY + 3);
        end

        // Consumer stalled: only RSP_DEPTH reads may be accepted.
        r_ready = 1'b0; a0 = accept_count;
        for (int i = 0; i < 12; i++) begin
            ar_valid = 1'b1; ar_addr = ADDR_WIDTH'($urandom());
            step();
        end
        ar_valid = 1'b0;
        check_eq("stall_accepted", accept_count - a0, RSP_DEPTH);
        check_eq("stall_ar_ready", int'(ar_ready), 0);
        r0 = resp_count; r_ready = 1'b1;
        drain(30, "stall", n);
        check_eq("stall_responses", resp_count - r0, RSP_DEPTH);
        check_eq("ar_ready_reassert", int'(ar_ready), 1);

        // Same-cycle read and write of word 5, then read again.
        ar_valid = 1'b1; ar_addr = ADDR_WIDTH'(5 * BPW);
        aw_valid = 1'b1; aw_addr = ADDR_WIDTH'(5 * BPW); aw_data = rand_store();
        step();
        aw_valid = 1'b0;
        step();
        ar_valid = 1'b0;
        drain(20, "rw_same_word", n);

        // Aliasing: beyond-depth address hits the same word as byte 8.
        aw_valid = 1'b1; aw_addr = ADDR_WIDTH'(MEM_DEPTH * BPW + 8); aw_data = rand_store();
        step();
        aw_valid = 1'b0;
        ar_valid = 1'b1; ar_addr = ADDR_WIDTH'(8);
        step();
        ar_addr = ADDR_WIDTH'(MEM_DEPTH * BPW + 8);
        step();
        ar_valid = 1'b0;
        drain(20, "alias", n);

        // Reset with three reads in flight: all of them must vanish.
        for (int i = 0; i < 3; i++) begin
            sv_addr[i] = ADDR_WIDTH'($urandom_range(0, MEM_DEPTH - 1) * BPW);
            ar_valid = 1'b1; ar_addr = sv_addr[i];
            step();
        end
        ar_valid = 1'b0; rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (8) step();
        check_eq("post_reset_responses", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) begin
            ar_valid = 1'b1; ar_addr = sv_addr[i];
            step();
        end
        ar_valid = 1'b0;
        drain(20, "post_reset_read", n);

        // Random traffic across the full address space.
        for (int i = 0; i < 400; i++) begin
            ar_valid = 1'($urandom_range(0, 1));
            ar_addr  = ADDR_WIDTH'($urandom());
            aw_valid = ($urandom_range(0, 3) == 0);
            aw_addr  = ADDR_WIDTH'($urandom());
            aw_data  = rand_store();
            r_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        ar_valid = 1'b0; aw_valid = 1'b0; r_ready = 1'b1;
        drain(40, "random", n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
